// File: rtl/tmr8_core.sv
// tmr8_core: 8-bit timer/counter with compare output.
// Modes: normal, clear-timer-on-compare (CTC) and, when TMR8_PWM_EN is
// defined, fast PWM with a double-buffered compare register.
// Without TMR8_PWM_EN, wgm=11 runs as normal mode with direct compare writes.
module tmr8_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic [1:0]       wgm,
  input  logic [1:0]       com,
  input  logic             tcnt_we,
  input  logic [WIDTH-1:0] tcnt_wdata,
  input  logic             ocr_we,
  input  logic [WIDTH-1:0] ocr_wdata,
  input  logic             foc,
  input  logic             tov_clr,
  input  logic             ocf_clr,
  output logic [WIDTH-1:0] tcnt,
  output logic [WIDTH-1:0] ocr,
  output logic             tov,
  output logic             ocf,
  output logic             oc,
  output logic             oc_oe
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic             ctc_mode;
  logic             pwm_mode;
  logic             tick;
  logic             match;
  logic             top;
  logic             tov_set;
  logic [WIDTH-1:0] tcnt_next;
  logic             oc_next;

  assign ctc_mode = (wgm == 2'b01);
`ifdef TMR8_PWM_EN
  assign pwm_mode = (wgm == 2'b11);
`else
  assign pwm_mode = 1'b0;
`endif

  // A counter write owns the edge: no count step and no match detection.
  assign tick    = clk_en && !tcnt_we;
  assign match   = tick && (tcnt == ocr);
  assign top     = tick && (tcnt == MAX);
  // In CTC the counter only reaches MAX->0 through a match when ocr==MAX.
  assign tov_set = top && (!ctc_mode || (ocr == MAX));

  assign oc_oe = (com != 2'b00) && !(pwm_mode && (com == 2'b01));

  // Next counter value: write, CTC clear on match, or increment with wrap.
  always_comb begin
    tcnt_next = tcnt;
    if (tcnt_we) begin
      tcnt_next = tcnt_wdata;
    end else if (tick) begin
      if (ctc_mode && match) tcnt_next = '0;
      else                   tcnt_next = tcnt + WIDTH'(1);
    end
  end

  // Next compare-output level; the wrap action outranks a same-tick match.
  always_comb begin
    oc_next = oc;
    if (pwm_mode) begin
      if (top) begin
        case (com)
          2'b10:   oc_next = 1'b1;
          2'b11:   oc_next = 1'b0;
          default: oc_next = oc;
        endcase
      end else if (match) begin
        case (com)
          2'b10:   oc_next = 1'b0;
          2'b11:   oc_next = 1'b1;
          default: oc_next = oc;
        endcase
      end
    end else if (match || foc) begin
      case (com)
        2'b01:   oc_next = !oc;
        2'b10:   oc_next = 1'b0;
        2'b11:   oc_next = 1'b1;
        default: oc_next = oc;
      endcase
    end
  end

  // Counter, flags and output pin registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
      tov  <= 1'b0;
      ocf  <= 1'b0;
      oc   <= 1'b0;
    end else begin
      tcnt <= tcnt_next;
      oc   <= oc_next;
      if (tov_set)      tov <= 1'b1;
      else if (tov_clr) tov <= 1'b0;
      if (match)        ocf <= 1'b1;
      else if (ocf_clr) ocf <= 1'b0;
    end
  end

`ifdef TMR8_PWM_EN
  logic [WIDTH-1:0] ocr_buf;

  // Buffer tracks every write so a later switch into PWM starts coherent;
  // in PWM the active value only changes at the MAX->0 wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ocr_buf <= '0;
      ocr     <= '0;
    end else begin
      if (ocr_we) ocr_buf <= ocr_wdata;
      if (!pwm_mode) begin
        if (ocr_we) ocr <= ocr_wdata;
      end else if (top) begin
        ocr <= ocr_we ? ocr_wdata : ocr_buf;
      end
    end
  end
`else
  // Compare register written directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    ocr <= '0;
    else if (ocr_we) ocr <= ocr_wdata;
  end
`endif

endmodule
